// File: rtl/commit_pkg.sv
// Shared defaults and the store-queue entry layout for the commit unit.
package commit_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int ADDR_W_DEF   = 48;
  localparam int SQ_DEPTH_DEF = 4;
  localparam int NUM_REGS     = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } sq_entry_t;

endpackage

// File: rtl/store_queue.sv
// Circular store queue: refuses push when full, ignores pop when empty.
module store_queue
  import commit_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH_DEF,
  parameter type entry_t = sq_entry_t,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[head_q];

  // A full queue refuses the push even if the head drains this cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[tail_q] = push_data;
      tail_d        = ptr_inc(tail_q);
    end
    if (pop_ok) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Commit stage: architectural register file writes plus a store queue
// draining to memory, with a retire pulse and a sticky protocol error.
module commit_unit
  import commit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int SQ_DEPTH = SQ_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      commit_ready_reg,
  input  logic                      commit_ready_mem,
  input  logic [DATA_W-1:0]         commit_data,
  input  logic [4:0]                commit_dest,
  input  logic [ADDR_W-1:0]         commit_addr,
  input  logic [2:0]                commit_entry,
  output logic                      commit_stall,
  input  logic [4:0]                rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      mem_wr_valid,
  output logic [ADDR_W-1:0]         mem_wr_addr,
  output logic [DATA_W-1:0]         mem_wr_data,
  input  logic                      mem_wr_ready,
  output logic                      retired_valid,
  output logic [2:0]                retired_entry,
  output logic [$clog2(SQ_DEPTH):0] sq_count,
  output logic                      protocol_err
);

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];
  logic              retired_valid_q, retired_valid_d;
  logic [2:0]        retired_entry_q, retired_entry_d;
  logic              protocol_err_q, protocol_err_d;

  sq_entry_t push_entry;
  sq_entry_t head_entry;
  logic      sq_full;
  logic      sq_empty;
  logic      reg_we;
  logic      mem_push;
  logic      accepted;

  // When both requests arrive the memory commit wins.
  assign reg_we   = commit_ready_reg & ~commit_ready_mem;
  assign mem_push = commit_ready_mem & ~sq_full;
  assign accepted = reg_we | mem_push;

  assign push_entry = '{addr: commit_addr, data: commit_data};

  store_queue #(
    .DEPTH   (SQ_DEPTH),
    .entry_t (sq_entry_t)
  ) u_sq (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_data (push_entry),
    .pop       (mem_wr_ready),
    .head      (head_entry),
    .full      (sq_full),
    .empty     (sq_empty),
    .count     (sq_count)
  );

  assign commit_stall = commit_ready_mem & sq_full;
  assign mem_wr_valid = ~sq_empty;
  assign mem_wr_addr  = head_entry.addr;
  assign mem_wr_data  = head_entry.data;
  assign rd_data      = rf_q[rd_addr];

  assign retired_valid = retired_valid_q;
  assign retired_entry = retired_entry_q;
  assign protocol_err  = protocol_err_q;

  always_comb begin
    rf_d = rf_q;
    if (reg_we) begin
      rf_d[commit_dest] = commit_data;
    end
  end

  always_comb begin
    retired_valid_d = accepted;
    retired_entry_d = accepted ? commit_entry : retired_entry_q;
    protocol_err_d  = protocol_err_q |
                      (commit_ready_reg & commit_ready_mem);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
      retired_valid_q <= 1'b0;
      retired_entry_q <= '0;
      protocol_err_q  <= 1'b0;
    end else begin
      rf_q            <= rf_d;
      retired_valid_q <= retired_valid_d;
      retired_entry_q <= retired_entry_d;
      protocol_err_q  <= protocol_err_d;
    end
  end

endmodule
